// File: rtl/fadd_issue_ctrl_if.sv
// Op-request and writeback handshake bundle for fadd_issue_ctrl.
// The master side issues ops and consumes results; the slave side is the controller.
interface fadd_issue_ctrl_if #(
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [TAG_W-1:0] in_rd;
    logic [31:0]      in_x1;
    logic [31:0]      in_x2;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_rd;
    logic [31:0]      out_y;
    logic             out_ovf;

    modport master (
        output in_valid, in_sub, in_rd, in_x1, in_x2, out_ready,
        input  in_ready, out_valid, out_rd, out_y, out_ovf
    );

    modport slave (
        input  in_valid, in_sub, in_rd, in_x1, in_x2, out_ready,
        output in_ready, out_valid, out_rd, out_y, out_ovf
    );
endinterface

// File: rtl/fadd_issue_ctrl.sv
// Issue/writeback controller around a fixed-latency, non-stallable fadd pipeline.
// Issue is credit-gated against the result FIFO so a completing op always has a slot.
module fadd_issue_ctrl #(
    parameter int FADD_LAT   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    fadd_issue_ctrl_if.slave  io,
    output logic [31:0]       fadd_x1,
    output logic [31:0]       fadd_x2,
    input  logic [31:0]       fadd_y,
    input  logic              fadd_ovf,
    output logic              ovf_sticky,
    input  logic              clr_sticky,
    output logic              busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [TAG_W-1:0] rd;
        logic [31:0]      y;
        logic             ovf;
    } entry_t;

    logic [FADD_LAT-1:0] vld_pipe_q, vld_pipe_d;
    logic [TAG_W-1:0]    rd_pipe_q [FADD_LAT];
    logic [TAG_W-1:0]    rd_pipe_d [FADD_LAT];
    entry_t              mem_q [FIFO_DEPTH];
    entry_t              mem_d [FIFO_DEPTH];
    entry_t              last_q, last_d;
    entry_t              head;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sticky_q, sticky_d;
    logic                accept, push, full, do_push, pop;
    int unsigned         inflight;

    // Credit: slots already owed to in-flight ops count as used; a same-cycle pop is not credited.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < FADD_LAT; i++) begin
            inflight += 32'(vld_pipe_q[i]);
        end
        io.in_ready = ~rst & ((32'(cnt_q) + inflight) < 32'(FIFO_DEPTH));
        accept      = io.in_valid & io.in_ready;
    end

    // FSUB is folded into an operand sign flip, including NaN/Inf operands.
    always_comb begin
        fadd_x1 = '0;
        fadd_x2 = '0;
        if (accept) begin
            fadd_x1 = io.in_x1;
            fadd_x2 = {io.in_x2[31] ^ io.in_sub, io.in_x2[30:0]};
        end
    end

    always_comb begin
        vld_pipe_d    = '0;
        rd_pipe_d     = rd_pipe_q;
        vld_pipe_d[0] = accept;
        rd_pipe_d[0]  = io.in_rd;
        for (int i = 1; i < FADD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            rd_pipe_d[i]  = rd_pipe_q[i-1];
        end
    end

    // Result FIFO: the tracked op at the pipe end lines up with fadd_y this cycle.
    always_comb begin
        push         = vld_pipe_q[FADD_LAT-1];
        full         = (cnt_q == CNT_W'(FIFO_DEPTH));
        do_push      = push & ~full;
        io.out_valid = (cnt_q != '0);
        pop          = io.out_valid & io.out_ready;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = '{rd: rd_pipe_q[FADD_LAT-1], y: fadd_y, ovf: fadd_ovf};
        end
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        cnt_d = cnt_q;
        if (do_push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!do_push && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // An empty FIFO keeps showing the most recently popped result.
        last_d = pop ? mem_q[rd_ptr_q] : last_q;
        head   = io.out_valid ? mem_q[rd_ptr_q] : last_q;

        sticky_d = (do_push & fadd_ovf) | (sticky_q & ~clr_sticky);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            rd_pipe_q  <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            sticky_q   <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            rd_pipe_q  <= rd_pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            sticky_q   <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign io.out_rd  = head.rd;
    assign io.out_y   = head.y;
    assign io.out_ovf = head.ovf;
    assign ovf_sticky = sticky_q;
    assign busy       = (|vld_pipe_q) | (cnt_q != '0);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Bench for fadd_issue_ctrl: a 2-stage fadd stand-in, a queue scoreboard fed on accept,
// directed scenarios and a randomized run with random writeback back-pressure.
module tb_fadd_issue_ctrl;
    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fadd_x1, fadd_x2;
    logic [31:0] fadd_y;
    logic        fadd_ovf;
    logic        ovf_sticky, busy;
    logic        clr_sticky = 1'b0;

    fadd_issue_ctrl_if #(.TAG_W(TAG_W)) ifc ();

    fadd_issue_ctrl #(.FADD_LAT(2), .FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .io         (ifc),
        .fadd_x1    (fadd_x1),
        .fadd_x2    (fadd_x2),
        .fadd_y     (fadd_y),
        .fadd_ovf   (fadd_ovf),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Single-precision add, round-to-nearest-even, subnormals flushed to zero; ovf on finite->Inf.
    function automatic logic [32:0] fp_add(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b, big, sml;
        logic [63:0] mb, ms, sum, lost;
        logic [23:0] m;
        logic [31:0] rem;
        logic        s;
        int          eb, es, d, e, p;
        a = a_in;
        b = b_in;
        if (a[30:23] == 8'hFF) return {1'b0, a};
        if (b[30:23] == 8'hFF) return {1'b0, b};
        if (a[30:23] == 8'h00) a = {a[31], 31'b0};
        if (b[30:23] == 8'h00) b = {b[31], 31'b0};
        big = a;
        sml = b;
        if (b[30:0] > a[30:0]) begin
            big = b;
            sml = a;
        end
        eb = int'(big[30:23]);
        es = int'(sml[30:23]);
        mb = (eb == 0) ? 64'd0 : ({40'd0, 1'b1, big[22:0]} << 32);
        ms = (es == 0) ? 64'd0 : ({40'd0, 1'b1, sml[22:0]} << 32);
        d  = eb - es;
        if (d >= 60) begin
            ms = (ms != 0) ? 64'd1 : 64'd0;
        end else begin
            lost = ms & ((64'd1 << d) - 64'd1);
            ms   = ms >> d;
            if (lost != 0) ms[0] = 1'b1;
        end
        sum = (big[31] == sml[31]) ? (mb + ms) : (mb - ms);
        if (sum == 0) return 33'd0;
        s = big[31];
        p = 63;
        while (!sum[p]) p--;
        e = eb + (p - 55);
        if (p == 56) sum = (sum >> 1) | {63'd0, sum[0]};
        else if (p < 55) sum = sum << (55 - p);
        m   = sum[55:32];
        rem = sum[31:0];
        if (rem > 32'h8000_0000 || (rem == 32'h8000_0000 && m[0])) begin
            m = m + 24'd1;
            if (m == 24'd0) begin
                m = 24'h80_0000;
                e++;
            end
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (e <= 0) return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return r;
            1:       return {r[31], 8'($urandom_range(250, 254)), r[22:0]};
            default: return {r[31], 8'($urandom_range(100, 150)), r[22:0]};
        endcase
    endfunction

    // fadd stand-in: two register stages, operands in cycle N -> result during N+2.
    logic [31:0] s1_x1 = '0, s1_x2 = '0;
    logic [32:0] s2_r = '0;
    always @(posedge clk) begin
        s1_x1 <= fadd_x1;
        s1_x2 <= fadd_x2;
        s2_r  <= fp_add(s1_x1, s1_x2);
    end
    assign fadd_y   = s2_r[31:0];
    assign fadd_ovf = s2_r[32];

    typedef struct {
        logic [TAG_W-1:0] rd;
        logic [31:0]      y;
        logic             ovf;
    } exp_t;
    exp_t exp_q[$];
    exp_t sb_e;
    logic [32:0] sb_r;
    logic        sb_acc;

    // Scoreboard: compare pops against the queue, then enqueue the model result of any accept.
    always @(negedge clk) begin
        sb_acc = ifc.in_valid & ifc.in_ready;
        chk("fadd_x1", fadd_x1, sb_acc ? ifc.in_x1 : 32'd0);
        chk("fadd_x2", fadd_x2, sb_acc ? {ifc.in_x2[31] ^ ifc.in_sub, ifc.in_x2[30:0]} : 32'd0);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_extra_result: got rd=%0d y=0x%0h, required no result", ifc.out_rd, ifc.out_y);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_rd", 64'(ifc.out_rd), 64'(sb_e.rd));
                    chk("sb_y", 64'(ifc.out_y), 64'(sb_e.y));
                    chk("sb_ovf", 64'(ifc.out_ovf), 64'(sb_e.ovf));
                end
            end
            if (sb_acc) begin
                sb_r = fp_add(ifc.in_x1, ifc.in_sub ? (ifc.in_x2 ^ 32'h8000_0000) : ifc.in_x2);
                exp_q.push_back('{rd: ifc.in_rd, y: sb_r[31:0], ovf: sb_r[32]});
            end
        end
    end

    // Tasks are entered and left just after a rising edge.
    task automatic issue(input logic sub, input logic [TAG_W-1:0] rd, input logic [31:0] x1, input logic [31:0] x2);
        bit ok;
        ok = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.in_sub   = sub;
        ifc.in_rd    = rd;
        ifc.in_x1    = x1;
        ifc.in_x2    = x2;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("issue_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 31;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ifc.out_valid) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int issued;
        ifc.in_valid  = 1'b0;
        ifc.in_sub    = 1'b0;
        ifc.in_rd     = '0;
        ifc.in_x1     = '0;
        ifc.in_x2     = '0;
        ifc.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd0);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_out_rd", 64'(ifc.out_rd), 64'd0);
        chk("rst_out_y", 64'(ifc.out_y), 64'd0);
        chk("rst_out_ovf", 64'(ifc.out_ovf), 64'd0);
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1.0 + 2.0, latency from accept to first out_valid
        ifc.out_ready = 1'b1;
        issue(1'b0, 5'd3, 32'h3F80_0000, 32'h4000_0000);
        wait_out(k);
        chk("t1_latency", 64'(k), 64'd3);
        chk("t1_y", 64'(ifc.out_y), 64'h4040_0000);
        chk("t1_rd", 64'(ifc.out_rd), 64'd3);
        chk("t1_ovf", 64'(ifc.out_ovf), 64'd0);
        @(posedge clk); #1;

        // 3.0 - 1.0 via FSUB sign flip
        ifc.in_valid = 1'b1;
        ifc.in_sub   = 1'b1;
        ifc.in_rd    = 5'd9;
        ifc.in_x1    = 32'h4040_0000;
        ifc.in_x2    = 32'h3F80_0000;
        @(negedge clk);
        chk("t2_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("t2_fadd_x2", 64'(fadd_x2), 64'hBF80_0000);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        wait_out(k);
        chk("t2_y", 64'(ifc.out_y), 64'h4000_0000);
        @(posedge clk); #1;

        // Credit exhaustion with writeback stalled, then in-order drain
        ifc.out_ready = 1'b0;
        ifc.in_sub    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_rd    = 5'(i);
            ifc.in_x1    = rand_fp();
            ifc.in_x2    = rand_fp();
            @(negedge clk);
            chk("t3_ready_fill", 64'(ifc.in_ready), 64'd1);
            @(posedge clk); #1;
        end
        ifc.in_rd = 5'd5;
        @(negedge clk);
        chk("t3_ready_full", 64'(ifc.in_ready), 64'd0);
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_head_hold", 64'(ifc.out_rd), 64'd1);
            chk("t3_ready_stall", 64'(ifc.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_pop_not_credited", 64'(ifc.in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_ready_after_pop", 64'(ifc.in_ready), 64'd1);
        repeat (5) @(posedge clk);
        #1;

        // Overflow, sticky flag, clear, and set-beats-clear
        issue(1'b0, 5'd7, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
        wait_out(k);
        chk("t4_ovf", 64'(ifc.out_ovf), 64'd1);
        chk("t4_y_inf", 64'(ifc.out_y), 64'h7F80_0000);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t4_sticky_held", 64'(ovf_sticky), 64'd1);
        end
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        @(negedge clk);
        chk("t4_sticky_before_clr_edge", 64'(ovf_sticky), 64'd1);
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        chk("t4_sticky_cleared", 64'(ovf_sticky), 64'd0);
        @(posedge clk); #1;
        clr_sticky = 1'b1;
        issue(1'b1, 5'd8, 32'hFF7F_FFFF, 32'h7F7F_FFFF);
        wait_out(k);
        chk("t4_set_wins", 64'(ovf_sticky), 64'd1);
        chk("t4_neg_inf", 64'(ifc.out_y), 64'hFF80_0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_clr_after_set", 64'(ovf_sticky), 64'd0);
        @(posedge clk); #1;
        clr_sticky = 1'b0;

        // Reset with two ops in flight drops them
        for (int i = 0; i < 2; i++) begin
            ifc.in_valid = 1'b1;
            ifc.in_rd    = 5'(20 + i);
            ifc.in_x1    = rand_fp();
            ifc.in_x2    = rand_fp();
            @(negedge clk);
            chk("t5_accept", 64'(ifc.in_ready), 64'd1);
            @(posedge clk); #1;
        end
        ifc.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_busy", 64'(busy), 64'd0);
            chk("t5_out_valid", 64'(ifc.out_valid), 64'd0);
            @(posedge clk); #1;
        end

        // Randomized ops with random writeback back-pressure
        issued = 0;
        for (int c = 0; c < 60000 && issued < 10000; c++) begin
            ifc.in_valid  = ($urandom_range(0, 3) != 0);
            ifc.in_sub    = 1'($urandom_range(0, 1));
            ifc.in_rd     = 5'($urandom_range(0, 31));
            ifc.in_x1     = rand_fp();
            ifc.in_x2     = rand_fp();
            ifc.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (ifc.in_valid && ifc.in_ready) issued++;
            @(posedge clk); #1;
        end
        chk("t6_issued", 64'(issued), 64'd10000);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("t6_drained_busy", 64'(busy), 64'd0);
        chk("t6_no_missing_results", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
